// File: rtl/seg7_scan_4dig_if.sv
// Display bus for the 4-digit multiplexed seven-segment scanner: value/dp
// requests in, active-low segment/anode drive and frame pulse out.
interface seg7_scan_4dig_if;
  logic [15:0] val;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  modport master (output val, dp_in, input seg, dp, an, frame);
  modport slave  (input val, dp_in, output seg, dp, an, frame);
endinterface

// File: rtl/seg7_scan_4dig.sv
// 4-digit seven-segment scanner with per-frame snapshot of val/dp_in.
// Define SEG7_LZB_EN to enable leading-zero blanking of digits 3..1.
module seg7_scan_4dig #(
  parameter int REFRESH_DIV = 50000
) (
  input logic               clk,
  input logic               r,
  seg7_scan_4dig_if.slave   bus
);

  localparam logic [19:0] PMAX = 20'(REFRESH_DIV - 1);

  logic [19:0] pcnt;
  logic [1:0]  idx;
  logic [15:0] snap_val;
  logic [3:0]  snap_dp;
  logic        rst_q;

  logic        adv;
  logic        take_snap;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  always_comb begin
    adv       = (pcnt == PMAX);
    // rst_q marks the first cycle after reset: initial snapshot, counters held
    take_snap = rst_q | (adv & (idx == 2'd3));
    case (idx)
      2'd0:    nib = snap_val[3:0];
      2'd1:    nib = snap_val[7:4];
      2'd2:    nib = snap_val[11:8];
      default: nib = snap_val[15:12];
    endcase
    blank = 1'b0;
`ifdef SEG7_LZB_EN
    case (idx)
      2'd1:    blank = (snap_val[15:4]  == 12'h000) && !snap_dp[1];
      2'd2:    blank = (snap_val[15:8]  == 8'h00)   && !snap_dp[2];
      2'd3:    blank = (snap_val[15:12] == 4'h0)    && !snap_dp[3];
      default: blank = 1'b0;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (r) begin
      pcnt      <= 20'd0;
      idx       <= 2'd0;
      snap_val  <= 16'h0000;
      snap_dp   <= 4'h0;
      rst_q     <= 1'b1;
      bus.an    <= 4'b1111;
      bus.seg   <= 7'h7F;
      bus.dp    <= 1'b1;
      bus.frame <= 1'b0;
    end else begin
      rst_q     <= 1'b0;
      bus.frame <= take_snap;
      if (take_snap) begin
        snap_val <= bus.val;
        snap_dp  <= bus.dp_in;
      end
      if (!rst_q) begin
        pcnt <= adv ? 20'd0 : pcnt + 20'd1;
        if (adv) idx <= idx + 2'd1;
      end
      if (rst_q || blank) begin
        bus.an  <= 4'b1111;
        bus.seg <= 7'h7F;
        bus.dp  <= 1'b1;
      end else begin
        bus.an  <= ~(4'b0001 << idx);
        bus.seg <= font(nib);
        bus.dp  <= ~snap_dp[idx];
      end
    end
  end

endmodule

// File: doc/seg7_scan_4dig.md
SEG7_SCAN_4DIG -- requirements
Module: seg7_scan_4dig

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clk cycles each digit is lit (legal range 1..2^20).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port r  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port val  input  16  four hex nibbles; digit0=val[3:0] (counter q), digit3=val[15:12].
REQ-005 SHALL have port dp_in  input  4  decimal point request per digit, bit n = digit n.
REQ-006 SHALL have port seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-007 SHALL have port dp  output  1  decimal point, active-low, registered.
REQ-008 SHALL have port an  output  4  digit enables, active-low, at most one low, registered.
REQ-009 SHALL have port frame  output  1  one-cycle pulse when a new snapshot of val/dp_in is taken.

Function
REQ-010 SHALL keep prescaler pcnt counting 0..REFRESH_DIV-1, wrapping to 0; "adv" = (pcnt==REFRESH_DIV-1).
REQ-011 SHALL keep 2-bit digit index idx; on adv, idx increments 0->1->2->3->0; otherwise it holds.
REQ-012 SHALL snapshot val and dp_in into internal registers on the first cycle after r deasserts, and on every adv with idx==3; frame SHALL be high in exactly those cycles.
REQ-013 SHALL ignore val/dp_in changes between snapshots (no tearing within a frame).
REQ-014 SHALL register an/seg/dp from current idx and snapshot: outputs reflect an idx change one cycle after it.
REQ-015 SHALL drive an = ~(1<<idx) when the digit is lit, 4'b1111 when blanked.
REQ-016 SHALL decode the selected nibble with active-low font (hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-017 SHALL drive dp = ~snapshot_dp[idx]; on a blanked digit seg=7F and dp=1.
REQ-018 SHALL, with REFRESH_DIV=1, advance idx every cycle and snapshot every 4th cycle.
REQ-019 SHALL give r priority over all other activity in the same cycle.

Reset
REQ-020 SHALL, while r=1, hold pcnt=0, idx=0, snapshots=0, an=4'b1111, seg=7'h7F, dp=1, frame=0.
REQ-021 SHALL, on r asserted mid-frame, abandon the frame; first post-reset cycle restarts at digit0 with frame=1.
REQ-022 SHALL produce first lit output (an=4'b1110) on the second cycle after r deasserts.

Configuration
REQ-023 SHALL use macro SEG7_LZB_EN to select leading-zero blanking.
REQ-024 SHALL, with SEG7_LZB_EN defined, blank digit n (n=3..1) when its snapshot nibble and all higher nibbles are 0 and its dp bit is 0; digit0 never blanked.
REQ-025 SHALL, without SEG7_LZB_EN, never blank any digit after reset; zeros display as 40.

Verification (REFRESH_DIV=4)
REQ-026 SHALL verify reset: r=1 for 3 cycles -> an=1111, seg=7F, dp=1, frame=0; release -> frame=1 next cycle, an=1110 the cycle after.
REQ-027 SHALL verify scan: val=16'h3A5F held -> an 1110/1101/1011/0111 each 4 cycles, seg 0E/12/08/30, frame every 16 cycles.
REQ-028 SHALL verify snapshot: val 16'h1234 -> 16'hFFFF while idx=1 -> digits 2,3 still show 24/79; next frame shows 0E on all.
REQ-029 SHALL verify blanking: val=16'h0007, dp_in=0 -> with SEG7_LZB_EN only digit0 lit (seg=78), an=1111 in digit 1-3 slots; without it, digits 1-3 show 40.
REQ-030 SHALL verify dp and mid-frame reset: dp_in=4'b0100, val=0 -> digit2 lit with dp=0 even under SEG7_LZB_EN; r pulse during idx=2 -> outputs per REQ-020, restart at digit0.
